// File: rtl/aap_decode_pkg.sv
// Shared decode types and constants: field positions, class and operation numbers, FSM states.
package aap_decode_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned HALF_W = 15;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM2_W = 6;
  localparam int unsigned IMM3_W = 9;

  localparam int unsigned LONG_BIT = 15;
  localparam int unsigned CLASS_HI = 14;
  localparam int unsigned CLASS_LO = 13;
  localparam int unsigned OPC_HI   = 12;
  localparam int unsigned OPC_LO   = 9;
  localparam int unsigned DEST_HI  = 8;
  localparam int unsigned DEST_LO  = 6;
  localparam int unsigned SRC1_HI  = 5;
  localparam int unsigned SRC1_LO  = 3;
  localparam int unsigned SRC2_HI  = 2;
  localparam int unsigned SRC2_LO  = 0;
  localparam int unsigned IMM3_HI  = 8;

  localparam logic [1:0] CLASS_0 = 2'd0;
  localparam logic [1:0] CLASS_1 = 2'd1;
  localparam logic [1:0] CLASS_2 = 2'd2;
  localparam logic [1:0] CLASS_3 = 2'd3;

  // Class 0 maps onto 0..15, class 1 onto 16..17.
  localparam logic [OP_W-1:0] OP_C0_BASE     = 6'd0;
  localparam logic [OP_W-1:0] OP_C0_LAST     = 6'd15;
  localparam logic [OP_W-1:0] OP_C1_BASE     = 6'd16;
  localparam logic [OP_W-1:0] OP_C1_LAST     = 6'd17;
  localparam logic [OP_W-1:0] NOP_OP_DEFAULT = 6'd0;

  typedef enum logic {
    S_FIRST,
    S_SECOND
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [REG_W-1:0]  u1;
    logic [IMM2_W-1:0] u2;
    logic [IMM3_W-1:0] u3;
    logic              valid;
    logic              illegal;
  } dec_out_t;

  function automatic dec_out_t bubble(input logic [OP_W-1:0] nop);
    dec_out_t b;
    b    = '0;
    b.op = nop;
    return b;
  endfunction

endpackage

// File: rtl/aap_op_lut.sv
// Combinational class/opcode to operation number mapping with illegal detection.
module aap_op_lut
  import aap_decode_pkg::*;
#(
  parameter logic [5:0] NOP_OP = NOP_OP_DEFAULT
) (
  input  logic [1:0]      cls,
  input  logic [3:0]      opcode,
  input  logic            force_illegal,
  output logic [OP_W-1:0] op_c,
  output logic            illegal_c
);

  always_comb begin
    op_c      = NOP_OP;
    illegal_c = 1'b1;
    if (!force_illegal) begin
      case (cls)
        CLASS_0: begin
          op_c      = OP_C0_BASE + 6'(opcode);
          illegal_c = 1'b0;
        end
        CLASS_1: begin
          if (opcode <= 4'd1) begin
            op_c      = OP_C1_BASE + 6'(opcode);
            illegal_c = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: registered decode of 16-bit words, optional two-word long form.
// Long instructions are compiled in with DECODE_LONG_INSTR_EN.
module decode_stage
  import aap_decode_pkg::*;
#(
  parameter logic [5:0] NOP_OP = NOP_OP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        stall,
  input  logic        flush,
  output logic [5:0]  operationnumber,
  output logic [2:0]  destination,
  output logic [2:0]  source_1,
  output logic [2:0]  source_2,
  output logic [2:0]  unsigned_1,
  output logic [5:0]  unsigned_2,
  output logic [8:0]  unsigned_3,
  output logic        op_valid,
  output logic        illegal
);

  state_t            state_q, state_d;
  logic [HALF_W-1:0] half_q, half_d;
  dec_out_t          out_q, out_d, dec_c;
  logic              accept_c;
  logic [HALF_W-1:0] body_c;
  logic              force_ill_c;
  logic [OP_W-1:0]   lut_op_c;
  logic              lut_ill_c;

  assign instr_ready = !stall && !flush;
  assign accept_c    = instr_valid && instr_ready;

  // In S_SECOND the held first half supplies the decoded fields.
  assign body_c = (state_q == S_SECOND) ? half_q : instr[HALF_W-1:0];

`ifdef DECODE_LONG_INSTR_EN
  assign force_ill_c = 1'b0;
`else
  assign force_ill_c = instr[LONG_BIT];
`endif

  aap_op_lut #(.NOP_OP(NOP_OP)) u_lut (
    .cls          (body_c[CLASS_HI:CLASS_LO]),
    .opcode       (body_c[OPC_HI:OPC_LO]),
    .force_illegal(force_ill_c),
    .op_c         (lut_op_c),
    .illegal_c    (lut_ill_c)
  );

  always_comb begin
    dec_c         = '0;
    dec_c.op      = lut_op_c;
    dec_c.illegal = lut_ill_c;
    dec_c.valid   = 1'b1;
    dec_c.dest    = body_c[DEST_HI:DEST_LO];
    dec_c.src1    = body_c[SRC1_HI:SRC1_LO];
    dec_c.src2    = body_c[SRC2_HI:SRC2_LO];
    dec_c.u1      = body_c[SRC2_HI:SRC2_LO];
    dec_c.u2      = {body_c[SRC1_HI:SRC1_LO], body_c[SRC2_HI:SRC2_LO]};
    dec_c.u3      = '0;
  end

  // Next state and next output register contents; flush beats stall beats accept.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    out_d   = out_q;
    if (flush) begin
      out_d   = bubble(NOP_OP);
      state_d = S_FIRST;
      half_d  = '0;
    end else if (stall) begin
      out_d = out_q;
    end else if (accept_c) begin
`ifdef DECODE_LONG_INSTR_EN
      if ((state_q == S_FIRST) && instr[LONG_BIT]) begin
        half_d  = instr[HALF_W-1:0];
        state_d = S_SECOND;
        out_d   = bubble(NOP_OP);
      end else begin
        out_d = dec_c;
        if (state_q == S_SECOND) begin
          out_d.u3 = instr[IMM3_HI:0];
        end
        state_d = S_FIRST;
        half_d  = '0;
      end
`else
      out_d   = dec_c;
      state_d = S_FIRST;
`endif
    end else begin
      out_d = bubble(NOP_OP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FIRST;
      half_q  <= '0;
      out_q   <= bubble(NOP_OP);
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      out_q   <= out_d;
    end
  end

  assign operationnumber = out_q.op;
  assign destination     = out_q.dest;
  assign source_1        = out_q.src1;
  assign source_2        = out_q.src2;
  assign unsigned_1      = out_q.u1;
  assign unsigned_2      = out_q.u2;
  assign unsigned_3      = out_q.u3;
  assign op_valid        = out_q.valid;
  assign illegal         = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vectors then randomized traffic against a word-level model.
module tb_decode_stage;

  localparam logic [5:0] NOP = 6'd0;
`ifdef DECODE_LONG_INSTR_EN
  localparam bit LONG = 1'b1;
`else
  localparam bit LONG = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        stall;
  logic        flush;
  logic [5:0]  operationnumber;
  logic [2:0]  destination, source_1, source_2, unsigned_1;
  logic [5:0]  unsigned_2;
  logic [8:0]  unsigned_3;
  logic        op_valid, illegal;

  always #5 clock = ~clock;

  decode_stage #(.NOP_OP(NOP)) dut (
    .clock          (clock),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .stall          (stall),
    .flush          (flush),
    .operationnumber(operationnumber),
    .destination    (destination),
    .source_1       (source_1),
    .source_2       (source_2),
    .unsigned_1     (unsigned_1),
    .unsigned_2     (unsigned_2),
    .unsigned_3     (unsigned_3),
    .op_valid       (op_valid),
    .illegal        (illegal)
  );

  int checks   = 0;
  int failures = 0;

  // Expected outputs and pending first half of a long instruction.
  int          e_op, e_dest, e_s1, e_s2, e_u1, e_u2, e_u3;
  bit          e_v, e_ill;
  bit          have_half;
  logic [15:0] half;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_bubble();
    e_op = int'(NOP); e_v = 1'b0; e_ill = 1'b0;
    e_dest = 0; e_s1 = 0; e_s2 = 0; e_u1 = 0; e_u2 = 0; e_u3 = 0;
  endtask

  // Decode a word straight from the field definitions.
  task automatic model_decode(input logic [15:0] w, input bit long_bad, input int u3);
    int cls, opc;
    cls = int'(w[14:13]);
    opc = int'(w[12:9]);
    e_v = 1'b1;
    if (long_bad || cls >= 2 || (cls == 1 && opc > 1)) begin
      e_ill = 1'b1; e_op = int'(NOP);
    end else begin
      e_ill = 1'b0; e_op = (cls == 0) ? opc : 16 + opc;
    end
    e_dest = int'(w[8:6]);
    e_s1   = int'(w[5:3]);
    e_s2   = int'(w[2:0]);
    e_u1   = e_s2;
    e_u2   = e_s1 * 8 + e_s2;
    e_u3   = u3;
  endtask

  task automatic model_edge(input bit v, input logic [15:0] w, input bit st, input bit fl);
    if (fl) begin
      set_bubble();
      have_half = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (v) begin
      if (LONG && !have_half && w[15]) begin
        have_half = 1'b1;
        half      = w;
        set_bubble();
      end else if (have_half) begin
        model_decode(half, 1'b0, int'(w[8:0]));
        have_half = 1'b0;
      end else begin
        model_decode(w, !LONG && w[15], 0);
      end
    end else begin
      set_bubble();
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/op"}, 32'(operationnumber), 32'(e_op));
    check({tag, "/op_valid"}, 32'(op_valid), 32'(e_v));
    check({tag, "/illegal"}, 32'(illegal), 32'(e_ill));
    if (e_v) begin
      check({tag, "/dest"}, 32'(destination), 32'(e_dest));
      check({tag, "/src1"}, 32'(source_1), 32'(e_s1));
      check({tag, "/src2"}, 32'(source_2), 32'(e_s2));
      check({tag, "/u1"}, 32'(unsigned_1), 32'(e_u1));
      check({tag, "/u2"}, 32'(unsigned_2), 32'(e_u2));
      check({tag, "/u3"}, 32'(unsigned_3), 32'(e_u3));
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
  task automatic step(input bit v, input logic [15:0] w, input bit st, input bit fl, input string tag);
    instr_valid = v; instr = w; stall = st; flush = fl;
    #1;
    check({tag, "/ready"}, 32'(instr_ready), 32'(!st && !fl));
    @(posedge clock);
    model_edge(v, w, st, fl);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    set_bubble();
    have_half = 1'b0;
    compare_all({tag, "/async"});
    check({tag, "/u3zero"}, 32'(unsigned_3), 32'd0);
    check({tag, "/destzero"}, 32'(destination), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
    have_half = 1'b0; half = '0;
    set_bubble();
    #1;
    compare_all("reset");
    check("reset/u2zero", 32'(unsigned_2), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    step(1'b1, 16'h0298, 1'b0, 1'b0, "w0298");
    check("w0298/op_k", 32'(operationnumber), 32'd1);
    check("w0298/dest_k", 32'(destination), 32'd2);
    check("w0298/src1_k", 32'(source_1), 32'd3);
    step(1'b1, 16'h1E6F, 1'b0, 1'b0, "w1E6F");
    check("w1E6F/op_k", 32'(operationnumber), 32'd15);
    check("w1E6F/u2_k", 32'(unsigned_2), 32'd47);
    step(1'b1, 16'h230E, 1'b0, 1'b0, "w230E");
    check("w230E/op_k", 32'(operationnumber), 32'd17);
    check("w230E/u1_k", 32'(unsigned_1), 32'd6);
    step(1'b1, 16'h6000, 1'b0, 1'b0, "w6000");
    check("w6000/ill_k", 32'(illegal), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, "bubble");
    check("bubble/ill_k", 32'(illegal), 32'd0);
    step(1'b1, 16'h1200, 1'b0, 1'b0, "c0op9");
    step(1'b1, 16'h2400, 1'b0, 1'b0, "c1op2_bad");
    step(1'b1, 16'h4000, 1'b0, 1'b0, "c2_bad");

    step(1'b1, 16'h8298, 1'b0, 1'b0, "long1");
    check("long1/valid_k", 32'(op_valid), LONG ? 32'd0 : 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, "long_wait");
    step(1'b1, 16'h01AB, 1'b0, 1'b0, "long2");

    step(1'b1, 16'h0298, 1'b0, 1'b0, "pre_stall");
    for (int i = 0; i < 3; i++) step(1'b1, 16'h230E, 1'b1, 1'b0, "stall");
    check("stall/op_k", 32'(operationnumber), 32'd1);
    step(1'b1, 16'h230E, 1'b1, 1'b1, "flush_over_stall");

    step(1'b1, 16'h8298, 1'b0, 1'b0, "fl_long1");
    step(1'b1, 16'h01AB, 1'b0, 1'b1, "fl_flush");
    step(1'b1, 16'h0298, 1'b0, 1'b0, "fl_after");
    check("fl_after/op_k", 32'(operationnumber), 32'd1);

    step(1'b1, 16'h8298, 1'b0, 1'b0, "rst_long1");
    do_reset("midreset");
    step(1'b1, 16'h0298, 1'b0, 1'b0, "rst_after");
    check("rst_after/u3_k", 32'(unsigned_3), 32'd0);

    for (int n = 0; n < 600; n++) begin
      logic [15:0] w;
      bit v, st, fl;
      w  = 16'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_reset");
      else step(v, w, st, fl, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
